// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Includes FSM state encoding, parity modes, line levels and a data-width mask helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } uart_parity_e;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    localparam int UART_MAX_BITS = 8;

    // Keeps only the low 5..8 bits selected by the data_bits code.
    function automatic logic [UART_MAX_BITS-1:0] data_mask(input logic [1:0] bits);
        return UART_MAX_BITS'(8'hFF >> (2'd3 - bits));
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with occupancy count, used as the transmit queue.
// Read data is the current head entry, valid whenever the FIFO is not empty.
module uart_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame format, baud divisor, TX FIFO and line break.
// Frame settings are shadowed at each frame start so mid-frame changes only affect later frames.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter int DATA_W     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          tx_valid_i,
    input  logic [DATA_W-1:0]             tx_data_i,
    output logic                          tx_ready_o,
    input  logic [DIV_W-1:0]              cfg_baud_div_i,
    input  logic [1:0]                    cfg_data_bits_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic                          tx_break_i,
    output logic                          tx_out_o,
    output logic                          tx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    uart_state_e       state_q, state_d;
    logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        nbits_q, nbits_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              tx_out_q, tx_out_d;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0] masked_data;
    logic [DIV_W-1:0]  div_eff;
    uart_parity_e      par_cfg;
    logic              bit_end;
    logic              start_frame;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_valid_i),
        .wdata_i (tx_data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign tx_ready_o  = ~fifo_full;
    assign tx_out_o    = tx_out_q;
    assign tx_busy_o   = (state_q != ST_IDLE);
    assign par_cfg     = uart_parity_e'(cfg_parity_i);
    assign masked_data = fifo_rdata & data_mask(cfg_data_bits_i);
    assign div_eff     = (cfg_baud_div_i < DIV_W'(2)) ? DIV_W'(2) : cfg_baud_div_i;
    assign bit_end     = (baud_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        div_d       = div_q;
        nbits_d     = nbits_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        start_frame = 1'b0;
        tx_out_d    = UART_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (tx_break_i)       state_d = ST_BREAK;
                else if (!fifo_empty) start_frame = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == nbits_q) begin
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && (bit_cnt_q == 3'd0)) bit_cnt_d = 3'd1;
                    else if (tx_break_i)                state_d   = ST_BREAK;
                    else if (!fifo_empty)               start_frame = 1'b1;
                    else                                state_d   = ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (!tx_break_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame start pops the head byte and snapshots the line configuration.
        if (start_frame) begin
            state_d    = ST_START;
            shift_d    = masked_data;
            div_d      = div_eff;
            nbits_d    = 3'd4 + {1'b0, cfg_data_bits_i};
            par_en_d   = (par_cfg == PAR_EVEN) || (par_cfg == PAR_ODD);
            par_bit_d  = (^masked_data) ^ (par_cfg == PAR_ODD);
            stop2_d    = cfg_stop2_i;
            baud_cnt_d = div_eff - DIV_W'(1);
        end else if (state_d == ST_IDLE || state_d == ST_BREAK) begin
            baud_cnt_d = '0;
        end else if (bit_end) begin
            baud_cnt_d = div_q - DIV_W'(1);
        end else begin
            baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end

        // Line level is registered, so it is derived from the state being entered.
        case (state_d)
            ST_IDLE:   tx_out_d = UART_IDLE;
            ST_START:  tx_out_d = UART_START;
            ST_DATA:   tx_out_d = shift_d[0];
            ST_PARITY: tx_out_d = par_bit_d;
            ST_STOP:   tx_out_d = UART_STOP;
            ST_BREAK:  tx_out_d = 1'b0;
            default:   tx_out_d = UART_IDLE;
        endcase
    end

    assign fifo_pop = start_frame;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            div_q      <= DIV_W'(2);
            nbits_q    <= 3'd7;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_out_q   <= UART_IDLE;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_out_q   <= tx_out_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, FIFO backpressure, break and async reset.
// Every line sample is compared against a hand-specified frame, one clock at a time.
module tb_uart_tx_cfg;

    logic        clk;
    logic        rst_n;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [15:0] cfg_baud_div;
    logic [1:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx_break;
    logic        tx_out;
    logic        tx_busy;
    logic [2:0]  fifo_level;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx_cfg #(
        .FIFO_DEPTH (4),
        .DIV_W      (16),
        .DATA_W     (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .tx_valid_i      (tx_valid),
        .tx_data_i       (tx_data),
        .tx_ready_o      (tx_ready),
        .cfg_baud_div_i  (cfg_baud_div),
        .cfg_data_bits_i (cfg_data_bits),
        .cfg_parity_i    (cfg_parity),
        .cfg_stop2_i     (cfg_stop2),
        .tx_break_i      (tx_break),
        .tx_out_o        (tx_out),
        .tx_busy_o       (tx_busy),
        .fifo_level_o    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting clock edge.
    task automatic push(input logic [7:0] d);
        int waited = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("push_ready", 32'(tx_ready), 1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        $display("push data=%02h waited=%0d", d, waited);
    endtask

    // Expected frame: start 0, n data bits LSB first, optional parity, nstop ones; each bit div clocks.
    task automatic expect_frame(input string tag, input logic [7:0] d, input int n,
                                input int par_en, input logic par_bit, input int nstop,
                                input int div);
        logic [15:0] bits;
        int len;
        int errs_before;
        bits = '0;
        len = 1;
        for (int i = 0; i < n; i++) begin
            bits[len] = d[i];
            len++;
        end
        if (par_en != 0) begin
            bits[len] = par_bit;
            len++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[len] = 1'b1;
            len++;
        end
        errs_before = n_bad;
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                chk(tag, 32'({tx_busy, tx_out}), 32'({1'b1, bits[b]}));
            end
        end
        $display("frame %s data=%02h bits=%0d clocks=%0d errors=%0d", tag, d, len, len * div,
                 n_bad - errs_before);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk(tag, 32'({tx_busy, tx_out, fifo_level}), 32'({1'b0, 1'b1, 3'd0}));
    endtask

    initial begin
        rst_n         = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        cfg_baud_div  = 16'd4;
        cfg_data_bits = 2'b11;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        tx_break      = 1'b0;
        @(negedge clk);
        chk("reset", 32'({tx_ready, tx_busy, tx_out, fifo_level}), 32'({1'b1, 1'b0, 1'b1, 3'd0}));
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 8N1 div 4, 0xA5
        push(8'hA5);
        expect_frame("t1_8n1_a5", 8'hA5, 8, 0, 1'b0, 1, 4);
        idle_check("t1_idle");

        // T2: 8E1 0x07 (parity 1), then 7O2 0x00 (parity 1)
        cfg_parity = 2'b01;
        push(8'h07);
        expect_frame("t2_8e1_07", 8'h07, 8, 1, 1'b1, 1, 4);
        idle_check("t2a_idle");
        cfg_data_bits = 2'b10;
        cfg_parity    = 2'b10;
        cfg_stop2     = 1'b1;
        push(8'h00);
        expect_frame("t2_7o2_00", 8'h00, 7, 1, 1'b1, 2, 4);
        idle_check("t2b_idle");

        // T3: div 2, 8N1, five back-to-back pushes fill the FIFO; extra push while full is dropped
        cfg_baud_div  = 16'd2;
        cfg_data_bits = 2'b11;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        push(8'h11);
        fork
            begin
                push(8'h22);
                push(8'h33);
                push(8'h44);
                push(8'h55);
                chk("t3_full", 32'({tx_ready, fifo_level}), 32'({1'b0, 3'd4}));
                tx_valid = 1'b1;
                tx_data  = 8'hC3;
                @(posedge clk);
                @(negedge clk);
                tx_valid = 1'b0;
                chk("t3_drop", 32'({tx_ready, fifo_level}), 32'({1'b0, 3'd4}));
            end
            begin
                expect_frame("t3_f1", 8'h11, 8, 0, 1'b0, 1, 2);
                expect_frame("t3_f2", 8'h22, 8, 0, 1'b0, 1, 2);
                expect_frame("t3_f3", 8'h33, 8, 0, 1'b0, 1, 2);
                expect_frame("t3_f4", 8'h44, 8, 0, 1'b0, 1, 2);
                expect_frame("t3_f5", 8'h55, 8, 0, 1'b0, 1, 2);
            end
        join
        idle_check("t3_idle");

        // T4: 5N1 0xFF sends five ones; switching to 8 bits mid-frame affects only the next frame
        cfg_data_bits = 2'b00;
        push(8'hFF);
        fork
            begin
                expect_frame("t4_5n1_ff", 8'hFF, 5, 0, 1'b0, 1, 2);
                expect_frame("t4_8n1_81", 8'h81, 8, 0, 1'b0, 1, 2);
            end
            begin
                repeat (4) @(negedge clk);
                cfg_data_bits = 2'b11;
                push(8'h81);
            end
        join
        idle_check("t4_idle");

        // Upper bits excluded from parity: 5E1 0xE0 -> parity 0; 6O1 0x21 -> parity 1
        cfg_data_bits = 2'b00;
        cfg_parity    = 2'b01;
        push(8'hE0);
        expect_frame("t4_5e1_e0", 8'hE0, 5, 1, 1'b0, 1, 2);
        idle_check("t4c_idle");
        cfg_data_bits = 2'b01;
        cfg_parity    = 2'b10;
        push(8'h21);
        expect_frame("t4_6o1_21", 8'h21, 6, 1, 1'b1, 1, 2);
        idle_check("t4d_idle");

        // Divisor 1 behaves as 2; parity code 11 means none
        cfg_baud_div  = 16'd1;
        cfg_data_bits = 2'b11;
        cfg_parity    = 2'b11;
        push(8'h5A);
        expect_frame("div1_5a", 8'h5A, 8, 0, 1'b0, 1, 2);
        idle_check("div1_idle");

        // T5: break raised mid-frame waits for the frame end, holds the queued byte
        cfg_baud_div = 16'd2;
        cfg_parity   = 2'b00;
        push(8'h55);
        fork
            expect_frame("t5_f1", 8'h55, 8, 0, 1'b0, 1, 2);
            begin
                repeat (5) @(negedge clk);
                tx_break = 1'b1;
                push(8'h0F);
            end
        join
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_break", 32'({tx_busy, tx_out, fifo_level}), 32'({1'b1, 1'b0, 3'd1}));
        end
        tx_break = 1'b0;
        @(negedge clk);
        chk("t5_gap", 32'({tx_busy, tx_out}), 32'({1'b0, 1'b1}));
        expect_frame("t5_f2", 8'h0F, 8, 0, 1'b0, 1, 2);
        idle_check("t5_idle");

        // T6: asynchronous reset during data bits
        cfg_baud_div = 16'd4;
        push(8'h00);
        push(8'h11);
        push(8'h22);
        repeat (6) @(negedge clk);
        chk("t6_pre", 32'({tx_busy, tx_out, fifo_level}), 32'({1'b1, 1'b0, 3'd2}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", 32'({tx_ready, tx_busy, tx_out, fifo_level}),
            32'({1'b1, 1'b0, 1'b1, 3'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t6_quiet", 32'({tx_busy, tx_out, fifo_level}), 32'({1'b0, 1'b1, 3'd0}));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
